// File: rtl/trig_align_pkg.sv
// Shared types for the SoT trigger-link alignment sequencer.
// Used with TRIG_ALIGN_AUTO_REALIGN_EN (optional automatic re-alignment).
package trig_align_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        WAIT  = 2'd2,
        READY = 2'd3
    } state_t;

    localparam int RETRY_W        = 4;
    localparam int UNSTABLE_CNT_W = 16;

    // A zero retry limit still allows one attempt before failing.
    function automatic logic [RETRY_W-1:0] eff_limit(input logic [RETRY_W-1:0] lim);
        return (lim == '0) ? RETRY_W'(1) : lim;
    endfunction

endpackage

// File: rtl/align_chan_tracker.sv
// Per-link bookkeeping: retry counter, sticky failed flag and
// rising-edge detection of the aligner's unstable flag.
module align_chan_tracker
    import trig_align_pkg::*;
(
    input  logic               clock,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               timeout_stb_i,
    input  logic               pending_i,
    input  logic [RETRY_W-1:0] limit_i,
    input  logic               unstable_i,
    output logic               failed_o,
    output logic               fail_next_o,
    output logic               rise_o
);

    logic [RETRY_W-1:0] retry_q;
    logic [RETRY_W-1:0] retry_inc;
    logic               unst_q;
    logic               hit;

    assign hit         = timeout_stb_i & pending_i;
    assign retry_inc   = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
    assign fail_next_o = failed_o | (hit & (retry_inc >= limit_i));
    assign rise_o      = unstable_i & ~unst_q;

    always_ff @(posedge clock) begin
        if (reset_i) begin
            retry_q  <= '0;
            failed_o <= 1'b0;
            unst_q   <= 1'b0;
        end else begin
            unst_q <= unstable_i;
            if (clear_i) begin
                retry_q  <= '0;
                failed_o <= 1'b0;
            end else begin
                if (hit)
                    retry_q <= retry_inc;
                failed_o <= fail_next_o;
            end
        end
    end

endmodule

// File: rtl/trig_align_sequencer.sv
// Sequences SoT alignment over all VFAT trigger links of one optohybrid.
// Define TRIG_ALIGN_AUTO_REALIGN_EN to re-reset links that go unstable in READY.
module trig_align_sequencer
    import trig_align_pkg::*;
#(
    parameter int NUM_VFATS    = 24,
    parameter int RESET_CYCLES = 4,
    parameter int TIMER_W      = 16
) (
    input  logic                      clock,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [NUM_VFATS-1:0]      vfat_mask_i,
    input  logic [NUM_VFATS-1:0]      sot_is_aligned_i,
    input  logic [NUM_VFATS-1:0]      sot_unstable_i,
    input  logic [TIMER_W-1:0]        timeout_i,
    input  logic [RETRY_W-1:0]        retry_limit_i,
    output logic [NUM_VFATS-1:0]      aligner_reset_o,
    output logic [NUM_VFATS-1:0]      failed_o,
    output logic                      all_ready_o,
    output logic                      busy_o,
    output logic [UNSTABLE_CNT_W-1:0] unstable_cnt_o,
    output logic [1:0]                state_o
);

    localparam int PH_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RESET_CYCLES - 1);

    state_t               state;
    logic [PH_W-1:0]      phase;
    logic [TIMER_W-1:0]   timer;
    logic [NUM_VFATS-1:0] target;
    logic [NUM_VFATS-1:0] enabled;
    logic [NUM_VFATS-1:0] pending;
    logic [NUM_VFATS-1:0] fail_next;
    logic [NUM_VFATS-1:0] rise;
    logic [NUM_VFATS-1:0] events;
    logic [NUM_VFATS-1:0] retarget;
    logic [RETRY_W-1:0]   lim;
    logic                 tmo_stb;

    assign lim      = eff_limit(retry_limit_i);
    assign enabled  = ~vfat_mask_i & ~failed_o;
    assign pending  = target & enabled & ~sot_is_aligned_i;
    assign tmo_stb  = (state == WAIT) && (|pending) && (timer >= timeout_i);
    assign retarget = pending & ~fail_next;
    assign events   = (state == READY) ? (rise & enabled) : '0;
    assign busy_o   = (state == RESET) || (state == WAIT);
    assign state_o  = state;

    for (genvar g = 0; g < NUM_VFATS; g++) begin : g_chan
        align_chan_tracker u_chan (
            .clock         (clock),
            .reset_i       (reset_i),
            .clear_i       (start_i),
            .timeout_stb_i (tmo_stb),
            .pending_i     (pending[g]),
            .limit_i       (lim),
            .unstable_i    (sot_unstable_i[g]),
            .failed_o      (failed_o[g]),
            .fail_next_o   (fail_next[g]),
            .rise_o        (rise[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset_i) begin
            state           <= IDLE;
            phase           <= '0;
            timer           <= '0;
            target          <= '0;
            aligner_reset_o <= '0;
            all_ready_o     <= 1'b0;
            unstable_cnt_o  <= '0;
        end else if (start_i) begin
            state           <= RESET;
            phase           <= '0;
            target          <= ~vfat_mask_i;
            aligner_reset_o <= ~vfat_mask_i;
            all_ready_o     <= 1'b0;
            unstable_cnt_o  <= '0;
        end else begin
            aligner_reset_o <= '0;
            all_ready_o     <= 1'b0;
            if ((|events) && (unstable_cnt_o != '1))
                unstable_cnt_o <= unstable_cnt_o + UNSTABLE_CNT_W'(1);
            unique case (state)
                IDLE: ;
                RESET: begin
                    if (phase == PH_LAST) begin
                        state <= WAIT;
                        timer <= '0;
                    end else begin
                        phase           <= phase + PH_W'(1);
                        aligner_reset_o <= target & ~vfat_mask_i;
                    end
                end
                WAIT: begin
                    if (pending == '0) begin
                        state <= READY;
                    end else if (tmo_stb) begin
                        // Only links still pending and not just failed go round again.
                        target <= retarget;
                        phase  <= '0;
                        if (retarget == '0) begin
                            state <= READY;
                        end else begin
                            state           <= RESET;
                            aligner_reset_o <= retarget & ~vfat_mask_i;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                READY: begin
                    all_ready_o <= ~|(enabled & ~sot_is_aligned_i);
`ifdef TRIG_ALIGN_AUTO_REALIGN_EN
                    if (|events) begin
                        target          <= events;
                        phase           <= '0;
                        state           <= RESET;
                        aligner_reset_o <= events & ~vfat_mask_i;
                        all_ready_o     <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_align_sequencer.sv
// Randomized bench for trig_align_sequencer with a behavioural frame-aligner
// model and an outcome-level reference (reset counts, failures, event count).
module tb_trig_align_sequencer;

    localparam int N = 24;

    logic          clock = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [N-1:0]  vfat_mask_i;
    logic [N-1:0]  sot_is_aligned_i = '0;
    logic [N-1:0]  sot_unstable_i;
    logic [15:0]   timeout_i;
    logic [3:0]    retry_limit_i;
    logic [N-1:0]  aligner_reset_o;
    logic [N-1:0]  failed_o;
    logic          all_ready_o;
    logic          busy_o;
    logic [15:0]   unstable_cnt_o;
    logic [1:0]    state_o;

    int total = 0;
    int bad   = 0;

    int dly[N];
    int acnt[N];
    int rst_cnt[N];
    int wid[N];
    int base[N];
    logic [N-1:0] prev_ar = '0;
    bit           wchk_en = 1'b1;
    logic [N-1:0] exp_failed = '0;
    int           exp_ucnt = 0;

    trig_align_sequencer dut (
        .clock            (clock),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .vfat_mask_i      (vfat_mask_i),
        .sot_is_aligned_i (sot_is_aligned_i),
        .sot_unstable_i   (sot_unstable_i),
        .timeout_i        (timeout_i),
        .retry_limit_i    (retry_limit_i),
        .aligner_reset_o  (aligner_reset_o),
        .failed_o         (failed_o),
        .all_ready_o      (all_ready_o),
        .busy_o           (busy_o),
        .unstable_cnt_o   (unstable_cnt_o),
        .state_o          (state_o)
    );

    always #12 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame aligner model: aligned dly[i] cycles after its reset drops (0 = never).
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (aligner_reset_o[i] === 1'b1) begin
                acnt[i] = 0;
                sot_is_aligned_i[i] = 1'b0;
                if (!prev_ar[i]) begin
                    rst_cnt[i]++;
                    wid[i] = 1;
                end else begin
                    wid[i]++;
                end
            end else begin
                if (prev_ar[i] && wchk_en)
                    chk("rst_width", wid[i], 4);
                if (acnt[i] < 100000)
                    acnt[i]++;
                sot_is_aligned_i[i] = (dly[i] > 0) && (acnt[i] >= dly[i]);
            end
        end
        prev_ar = aligner_reset_o;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget);
        int k = 0;
        while (state_o !== s && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("wait_state", state_o, s);
    endtask

    task automatic start_pulse();
        for (int i = 0; i < N; i++)
            base[i] = rst_cnt[i];
        start_i = 1'b1;
        @(negedge clock);
        start_i = 1'b0;
        exp_ucnt = 0;
    endtask

    task automatic run_seq(input logic [N-1:0] mask, input int tmo, input int lim);
        int L;
        int er;
        L = (lim == 0) ? 1 : lim;
        vfat_mask_i   = mask;
        timeout_i     = 16'(tmo);
        retry_limit_i = 4'(lim);
        start_pulse();
        wait_state(2'd3, 3000);
        tick(2);
        exp_failed = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                er = 0;
            end else if (dly[i] > 0 && dly[i] <= tmo + 1) begin
                er = 1;
            end else begin
                er = L;
                exp_failed[i] = 1'b1;
            end
            chk($sformatf("rst_count%0d", i), rst_cnt[i] - base[i], er);
        end
        chk("failed", failed_o, exp_failed);
        chk("all_ready", all_ready_o, 1);
        chk("busy_ready", busy_o, 0);
        chk("ucnt_start", unstable_cnt_o, exp_ucnt);
    endtask

    initial begin
        logic [N-1:0] u;
        logic [N-1:0] prev_u;
        logic [N-1:0] pair;
        logic [N-1:0] m;
        int tmo;
        int r;
        reset_i = 1'b1;
        start_i = 1'b0;
        vfat_mask_i = '0;
        sot_unstable_i = '0;
        timeout_i = 16'd100;
        retry_limit_i = 4'd3;
        for (int i = 0; i < N; i++) begin
            dly[i] = 10;
            acnt[i] = 0;
            rst_cnt[i] = 0;
            wid[i] = 0;
        end
        tick(3);
        chk("rst_state", state_o, 0);
        chk("rst_ar", aligner_reset_o, 0);
        chk("rst_failed", failed_o, 0);
        chk("rst_ready", all_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ucnt", unstable_cnt_o, 0);
        reset_i = 1'b0;
        tick(2);
        chk("idle_state", state_o, 0);
        chk("idle_ready", all_ready_o, 0);

        run_seq('0, 100, 3);

        dly[5] = 0;
        run_seq('0, 20, 3);

        dly[5] = 10;
        start_pulse();
        chk("restart_failed", failed_o, 0);
        chk("restart_state", state_o, 1);
        wait_state(2'd3, 3000);
        tick(2);
        chk("restart_ready", all_ready_o, 1);
        chk("restart_failed2", failed_o, 0);

        dly[2] = 21;
        run_seq('0, 20, 1);
        dly[2] = 22;
        run_seq('0, 20, 2);
        dly[2] = 10;

        dly[3] = 0;
        wchk_en = 1'b0;
        vfat_mask_i = '0;
        timeout_i = 16'd20;
        retry_limit_i = 4'd2;
        start_pulse();
        vfat_mask_i[3] = 1'b1;
        tick(1);
        chk("mask_drop3", aligner_reset_o[3], 0);
        chk("mask_keep0", aligner_reset_o[0], 1);
        wait_state(2'd3, 3000);
        tick(2);
        wchk_en = 1'b1;
        chk("mask_failed3", failed_o[3], 0);
        chk("mask_rst3", rst_cnt[3] - base[3], 1);
        chk("mask_ready", all_ready_o, 1);
        dly[3] = 10;
        exp_failed = '0;

        pair = '0;
        pair[1] = 1'b1;
        pair[7] = 1'b1;
        sot_unstable_i = pair;
        exp_ucnt++;
        tick(1);
        chk("unst_cnt", unstable_cnt_o, exp_ucnt);
`ifdef TRIG_ALIGN_AUTO_REALIGN_EN
        chk("realign_state", state_o, 1);
        chk("realign_ar1", aligner_reset_o, pair);
        for (int c = 0; c < 3; c++) begin
            tick(1);
            chk("realign_ar", aligner_reset_o, pair);
        end
        tick(1);
        chk("realign_ar_end", aligner_reset_o, 0);
        chk("realign_wait", state_o, 2);
        sot_unstable_i = '0;
        wait_state(2'd3, 3000);
        tick(2);
        chk("realign_ready", all_ready_o, 1);
        chk("realign_cnt", unstable_cnt_o, exp_ucnt);
`else
        chk("unst_state", state_o, 3);
        tick(1);
        chk("unst_state2", state_o, 3);
        chk("unst_ready", all_ready_o, 1);
        prev_u = sot_unstable_i;
        for (int c = 0; c < 150; c++) begin
            u = N'($urandom & $urandom & $urandom);
            if ((u & ~prev_u & ~vfat_mask_i & ~exp_failed) != '0)
                exp_ucnt++;
            sot_unstable_i = u;
            prev_u = u;
            tick(1);
            chk("unst_rand", unstable_cnt_o, exp_ucnt);
        end
        chk("unst_rand_state", state_o, 3);
        sot_unstable_i = '0;
        tick(1);
`endif

        for (int s = 0; s < 6; s++) begin
            m = N'($urandom & $urandom & $urandom);
            tmo = $urandom_range(15, 40);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)
                    dly[i] = 0;
                else if (r == 1)
                    dly[i] = tmo + 1;
                else if (r == 2)
                    dly[i] = tmo + 2;
                else
                    dly[i] = $urandom_range(1, 12);
            end
            run_seq(m, tmo, $urandom_range(0, 4));
        end

        for (int i = 0; i < N; i++)
            dly[i] = 10;
        vfat_mask_i = '0;
        start_pulse();
        wait_state(2'd2, 50);
        reset_i = 1'b1;
        tick(1);
        chk("wrst_state", state_o, 0);
        chk("wrst_ar", aligner_reset_o, 0);
        chk("wrst_failed", failed_o, 0);
        chk("wrst_ready", all_ready_o, 0);
        chk("wrst_busy", busy_o, 0);
        chk("wrst_ucnt", unstable_cnt_o, 0);
        reset_i = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
